mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit implementing the RV32M operation set, parametrised in datapath width.
- Sits beside the combinational ALU in the multicycle datapath. The control FSM issues a single-cycle start, stalls while busy, and writes result on done.
- Radix-2 shift-add multiplier and restoring divider share one counter and one accumulator.

Parameters:
WIDTH, 32, operand/result width in bits; legal values are even and >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; accepted only when busy=0
op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  input  WIDTH  multiplicand / dividend
src_b  input  WIDTH  multiplier / divisor
result  output  WIDTH  final result; held stable until the next FIX state
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; result is valid in the same cycle

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result=0, busy=0, done=0; counter and accumulator cleared.
- Reset mid-operation aborts immediately with no done pulse. The first start after rst_n rises is accepted normally.
- States: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on start=1:
  - Latch op.
  - Latch operand sign flags: src_a is signed for MULH, MULHSU, DIV, REM; src_b is signed for MULH, DIV, REM.
  - Latch operand magnitudes (absolute values where signed); counter=0.
- CALC:
  - One iteration per cycle for exactly WIDTH cycles, then go to FIX.
  - Multiply: 2*WIDTH-bit product; add the multiplicand when the multiplier LSB is 1, then shift right.
  - Divide: restoring; shift the remainder:quotient pair left, trial-subtract the divisor, set the quotient bit when the result is non-negative.
- FIX, 1 cycle:
  - Negate the product if the sign flags differ.
  - Quotient sign = sign_a XOR sign_b. Remainder sign = sign_a.
  - Select the result: MUL takes the low WIDTH bits; MULH/MULHSU/MULHU take the high WIDTH bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register the result. Go to DONE.
- DONE, 1 cycle: done=1, then go to IDLE.
- Latency: start accepted in cycle 0; done=1 in cycle WIDTH+2; busy=0 again in cycle WIDTH+3.
- start while busy=1 is ignored; op, src_a and src_b are not re-sampled.
- Divide by zero, no trap:
  - DIV/DIVU give all ones.
  - REM/REMU give src_a.
  - Negation fix-up is suppressed for this case.
- Signed overflow (DIV with src_a = most negative value, src_b = -1):
  - Quotient is the most negative value.
  - Remainder is 0.
- All arithmetic is modulo 2^WIDTH. No exceptions, no flags.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: divide-by-zero and signed-overflow cases are detected in IDLE on start and go IDLE -> FIX directly, skipping CALC. done=1 in cycle 2.
- Not defined: these cases run the full CALC sequence and produce identical results with standard WIDTH+2 latency.
- Result values are identical in both builds.

Test Plan:
All scenarios use WIDTH=32.
- MUL src_a=7, src_b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly in cycle 34, busy low in cycle 35.
- High-half multiplies:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- Boundaries:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
  - Repeat with MDU_EARLY_OUT_EN defined: done in cycle 2.
- Start ignored while busy: start MUL 3*4, pulse start with DIV 9/3 in cycle 10 -> single done in cycle 34, result 12.
- Reset mid-op: assert rst_n=0 in cycle 15 of a DIV -> result=0, busy=0, no done. The next start (MUL 6*7) gives 42.

Source files
------------

// File: rtl/mdu_iter_if.sv
// Handshake/operand bundle between the control FSM (master) and the
// iterative multiply/divide unit (slave).
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output start, op, src_a, src_b,
    input  result, busy, done
  );

  modport slave (
    input  start, op, src_a, src_b,
    output result, busy, done
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Optional MDU_EARLY_OUT_EN: divide-by-zero/overflow skip CALC (IDLE -> FIX).
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mdu_iter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               dz_q, dz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Start-time decode of the incoming request
  logic             signed_a, signed_b, neg_a, neg_b, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    signed_a = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10);
    signed_b = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] == 2'b01);
    neg_a    = signed_a & bus.src_a[WIDTH-1];
    neg_b    = signed_b & bus.src_b[WIDTH-1];
    mag_a    = neg_a ? -bus.src_a : bus.src_a;
    mag_b    = neg_b ? -bus.src_b : bus.src_b;
    div_zero = bus.op[2] & (bus.src_b == '0);
    div_ovf  = bus.op[2] & ~bus.op[0] & (bus.src_a == MinNeg) & (bus.src_b == '1);
  end

  // Per-iteration datapath
  logic [WIDTH:0]     mul_sum, div_sh, div_trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_sh - {1'b0, b_q};
    prod      = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quot      = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem       = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    // Corner cases are forced so results do not depend on whether CALC ran
    if (dz_q) begin
      quot = '1;
      rem  = sa_q ? -a_q : a_q;
    end else if (ovf_q) begin
      quot = MinNeg;
      rem  = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d  = bus.op;
          sa_d  = neg_a;
          sb_d  = neg_b;
          dz_d  = div_zero;
          ovf_d = div_ovf;
          a_d   = mag_a;
          b_d   = mag_b;
          cnt_d = '0;
          // Multiply keeps the multiplier in the low half; divide the dividend
          acc_d = {{WIDTH{1'b0}}, bus.op[2] ? mag_a : mag_b};
`ifdef MDU_EARLY_OUT_EN
          state_d = (div_zero || div_ovf) ? StFix : StCalc;
`else
          state_d = StCalc;
`endif
        end
      end
      StCalc: begin
        if (op_q[2]) begin
          if (!div_trial[WIDTH]) begin
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        unique case (op_q)
          3'b000:                 result_d = prod[WIDTH-1:0];
          3'b001, 3'b010, 3'b011: result_d = prod[2*WIDTH-1:WIDTH];
          3'b100, 3'b101:         result_d = quot;
          default:                result_d = rem;
        endcase
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StDone);

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (WIDTH=32): directed vectors push expected
// result and done cycle; a negedge monitor pops and compares on done.
module tb_mdu_iter;

  localparam int W = 32;
`ifdef MDU_EARLY_OUT_EN
  localparam int LatEdge = 2;
`else
  localparam int LatEdge = W + 2;
`endif
  localparam int LatStd = W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [W-1:0] exp_res_q[$];
  int           exp_cyc_q[$];
  string        exp_nm_q[$];

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        automatic logic [W-1:0] er = exp_res_q.pop_front();
        automatic int           ec = exp_cyc_q.pop_front();
        automatic string        en = exp_nm_q.pop_front();
        chk({en, "_result"}, bus.result, er);
        chk({en, "_done_cycle"}, W'(cyc), W'(ec));
      end
    end
  end

  // Caller is #1 after a posedge; start is sampled at the next edge (cycle 0 = now)
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int lat, input string nm);
    int t0;
    t0 = cyc;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    exp_res_q.push_back(exp);
    exp_cyc_q.push_back(t0 + lat);
    exp_nm_q.push_back(nm);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (lat) @(posedge clk);
    #1;
    chk({nm, "_busy_after"}, W'(bus.busy), '0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    #23;
    chk("reset_result", bus.result, '0);
    chk("reset_busy", W'(bus.busy), '0);
    chk("reset_done", W'(bus.done), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LatStd, "mul_7_m3");
    run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, LatStd, "mulh_min_min");
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LatStd, "mulhu_max");
    run_op(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LatStd, "mulhsu_m1_2");
    run_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LatStd, "div_m7_2");
    run_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LatStd, "rem_m7_2");
    run_op(3'b101, 32'd100,      32'd7,        32'd14,       LatStd, "divu_100_7");
    run_op(3'b111, 32'd100,      32'd7,        32'd2,        LatStd, "remu_100_7");
    run_op(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, LatEdge, "div_5_0");
    run_op(3'b110, 32'd5,        32'd0,        32'd5,        LatEdge, "rem_5_0");
    run_op(3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, LatEdge, "rem_m5_0");
    run_op(3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, LatEdge, "divu_9_0");
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LatEdge, "div_ovf");
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        LatEdge, "rem_ovf");

    // Start while busy: second request must be ignored
    begin
      int t0;
      t0 = cyc;
      bus.op = 3'b000; bus.src_a = 32'd3; bus.src_b = 32'd4; bus.start = 1'b1;
      exp_res_q.push_back(32'd12);
      exp_cyc_q.push_back(t0 + LatStd);
      exp_nm_q.push_back("busy_ignore");
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      bus.op = 3'b100; bus.src_a = 32'd9; bus.src_b = 32'd3; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (24) @(posedge clk);
      #1;
      chk("busy_ignore_busy_after", W'(bus.busy), '0);
    end

    // Reset mid-operation: abort with no done
    begin
      bus.op = 3'b100; bus.src_a = 32'd1000; bus.src_b = 32'd10; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      chk("midrst_busy_before", W'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_result", bus.result, '0);
      chk("midrst_busy", W'(bus.busy), '0);
      chk("midrst_done", W'(bus.done), '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (W + 4) @(posedge clk);
      #1;
    end

    run_op(3'b000, 32'd6, 32'd7, 32'd42, LatStd, "mul_after_rst");

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", W'(exp_res_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish by %0t expected earlier", $time);
    $fatal(1);
  end

endmodule
